// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state codes, flag bundle and opcode helpers for alu_seq.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_NOT = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_SLT = 4'h6;
   localparam logic [3:0] OP_EQ  = 4'h7;
   localparam logic [3:0] OP_SLL = 4'h8;
   localparam logic [3:0] OP_SRL = 4'h9;
   localparam logic [3:0] OP_SRA = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic less;
      logic equal;
   } flags_t;

   // Ops that may need more than one cycle (shifts only when the amount is non-zero).
   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_MUL);
   endfunction

   // Ops that route through the add/sub datapath with the carry-in set.
   function automatic logic uses_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT) || (op == OP_EQ);
   endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD/SUB/SLT/EQ and the MUL accumulate step.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;

   // Invert b when subtracting; the +cin completes the two's complement.
   always_comb begin
      b_eff                = b ^ {WIDTH{cin}};
      {carry_out, sum}     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      overflow             = (a[WIDTH-1] == b_eff[WIDTH-1]) && (a[WIDTH-1] != sum[WIDTH-1]);
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shifts and shift-add multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero_flag,
   output logic             less_flag,
   output logic             equal_flag
);

   localparam int CW = SHW + 1;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   flags_t           flags_q, flags_d;

   logic [WIDTH-1:0] as_a, as_b, as_sum;
   logic             as_cin, as_carry, as_ovf;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] single_res;
   flags_t           single_flags;

   // While iterating, the adder accumulates the multiplicand; otherwise it serves the input ops.
   always_comb begin
      if (state_q == BUSY) begin
         as_a   = acc_q;
         as_b   = mcand_q;
         as_cin = 1'b0;
      end else begin
         as_a   = a;
         as_b   = b;
         as_cin = uses_sub(op);
      end
   end

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a         (as_a),
      .b         (as_b),
      .cin       (as_cin),
      .sum       (as_sum),
      .carry_out (as_carry),
      .overflow  (as_ovf)
   );

   // One iteration of the in-flight multi-cycle op.
   always_comb begin
      case (op_q)
         OP_SLL:  step_val = {acc_q[WIDTH-2:0], 1'b0};
         OP_SRL:  step_val = {1'b0, acc_q[WIDTH-1:1]};
         OP_SRA:  step_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
         OP_MUL:  step_val = mplier_q[0] ? as_sum : acc_q;
         default: step_val = acc_q;
      endcase
   end

   // Result and flags for ops that complete on the accept edge (incl. zero-amount shifts).
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
      single_res   = '0;
      single_flags = '0;
      case (op)
         OP_ADD, OP_SUB, OP_SLT, OP_EQ: begin
            single_res            = as_sum;
            single_flags.carry    = as_carry;
            single_flags.overflow = as_ovf;
            single_flags.less     = (op == OP_SLT) && (as_ovf ^ as_sum[WIDTH-1]);
            single_flags.equal    = (op == OP_EQ) && (as_sum == '0);
         end
         OP_NOT:                 single_res = ~a;
         OP_AND:                 single_res = a & b;
         OP_OR:                  single_res = a | b;
         OP_XOR:                 single_res = a ^ b;
         OP_SLL, OP_SRL, OP_SRA: single_res = a;
         default:                single_res = '0;
      endcase
      single_flags.zero = (single_res == '0);
   end

   // FSM and datapath next-state: accept, iterate, then hold the result until taken.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d = op;
               if (op == OP_MUL) begin
                  acc_d    = '0;
                  mcand_d  = a;
                  mplier_d = b;
                  cnt_d    = CW'(WIDTH);
                  state_d  = BUSY;
               end else if (is_multicycle(op) && (b[SHW-1:0] != '0)) begin
                  acc_d   = a;
                  cnt_d   = {1'b0, b[SHW-1:0]};
                  state_d = BUSY;
               end else begin
                  result_d = single_res;
                  flags_d  = single_flags;
                  state_d  = DONE;
               end
            end
         end
         BUSY: begin
            acc_d    = step_val;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               result_d     = step_val;
               flags_d      = '0;
               flags_d.zero = (step_val == '0);
               state_d      = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and data registers; reset discards any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= OP_ADD;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge value of its peers.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign result     = result_q;
   assign carry_out  = flags_q.carry;
   assign overflow   = flags_q.overflow;
   assign zero_flag  = flags_q.zero;
   assign less_flag  = flags_q.less;
   assign equal_flag = flags_q.equal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, result;
   logic [3:0] op;
   logic       carry_out, overflow, zero_flag, less_flag, equal_flag;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
      logic       l;
      logic       e;
      int         lat;
   } exp_t;

   alu_seq #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .op         (op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .carry_out  (carry_out),
      .overflow   (overflow),
      .zero_flag  (zero_flag),
      .less_flag  (less_flag),
      .equal_flag (equal_flag)
   );

   always #5 clk = ~clk;

   // Expected outcome from plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
      exp_t             e;
      int               ua, ub, sa, sb, s, n;
      logic signed [7:0] sx;
      ua = int'(x);
      ub = int'(y);
      sa = int'($signed(x));
      sb = int'($signed(y));
      n  = int'(y[2:0]);
      sx = $signed(x);
      e  = '0;
      e.lat = 1;
      case (o)
         4'h0: begin
            e.res = 8'(ua + ub);
            e.c   = (ua + ub) > 255;
            s     = sa + sb;
            e.v   = (s > 127) || (s < -128);
         end
         4'h1, 4'h6, 4'h7: begin
            e.res = 8'(ua - ub);
            e.c   = (ua >= ub);
            s     = sa - sb;
            e.v   = (s > 127) || (s < -128);
            e.l   = (o == 4'h6) && (sa < sb);
            e.e   = (o == 4'h7) && (ua == ub);
         end
         4'h2: e.res = ~x;
         4'h3: e.res = x & y;
         4'h4: e.res = x | y;
         4'h5: e.res = x ^ y;
         4'h8: begin e.res = x << n;        e.lat = n + 1; end
         4'h9: begin e.res = x >> n;        e.lat = n + 1; end
         4'hA: begin e.res = 8'(sx >>> n);  e.lat = n + 1; end
         4'hB: begin e.res = 8'(ua * ub);   e.lat = 9;     end
         default: e.res = 8'h00;
      endcase
      e.z = (e.res == 8'h00);
      return e;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      #12;
      total++;
      if ({in_ready, out_valid, result, carry_out, overflow, zero_flag, less_flag, equal_flag} !== {2'b10, 8'h00, 5'b00000}) begin
         bad++;
         $display("FAIL reset: got rdy=%b vld=%b res=%h flags=%b%b%b%b%b, want rdy=1 vld=0 res=00 flags=00000",
                  in_ready, out_valid, result, carry_out, overflow, zero_flag, less_flag, equal_flag);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one op, scramble inputs after accept, check latency, result/flags, hold and release.
   task automatic test_one_op(input string name, input logic [7:0] xa, input logic [7:0] xb,
                              input logic [3:0] xo, input int hold);
      exp_t e;
      int   lat;
      e = model(xa, xb, xo);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s ready_before: got %b want 1", name, in_ready);
      end
      a = xa; b = xb; op = xo; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat != e.lat) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
      end
      total++;
      if ({result, carry_out, overflow, zero_flag, less_flag, equal_flag} !== {e.res, e.c, e.v, e.z, e.l, e.e}) begin
         bad++;
         $display("FAIL %s result: got res=%h c=%b v=%b z=%b l=%b e=%b want res=%h c=%b v=%b z=%b l=%b e=%b",
                  name, result, carry_out, overflow, zero_flag, less_flag, equal_flag,
                  e.res, e.c, e.v, e.z, e.l, e.e);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         total++;
         if ({out_valid, in_ready, result, carry_out, overflow, zero_flag, less_flag, equal_flag} !==
             {2'b10, e.res, e.c, e.v, e.z, e.l, e.e}) begin
            bad++;
            $display("FAIL %s hold%0d: got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h", name, i,
                     out_valid, in_ready, result, e.res);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready} !== 2'b01) begin
         bad++;
         $display("FAIL %s release: got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_directed;
      test_one_op("add_ovf",   8'h7F, 8'h01, 4'h0, 0);
      test_one_op("sub_borrow", 8'h00, 8'h01, 4'h1, 0);
      test_one_op("slt_min",   8'h80, 8'h01, 4'h6, 0);
      test_one_op("eq_same",   8'h5A, 8'h5A, 4'h7, 0);
      test_one_op("sra_3",     8'h90, 8'h03, 4'hA, 0);
      test_one_op("sll_0",     8'hA5, 8'h00, 4'h8, 0);
      test_one_op("srl_max",   8'hC3, 8'hFF, 4'h9, 0);
      test_one_op("reserved",  8'h12, 8'h34, 4'hD, 0);
      test_one_op("mul_hold",  8'hFD, 8'h05, 4'hB, 5);
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         test_one_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), i % 3);
      end
   endtask

   // in_valid held through the output handshake must not be accepted in that same cycle.
   task automatic test_back_to_back;
      @(negedge clk);
      a = 8'h01; b = 8'h01; op = 4'h0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 8'h03; b = 8'h04; out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, result} !== {2'b01, 8'h02}) begin
         bad++;
         $display("FAIL b2b_handshake: got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=02", out_valid, in_ready, result);
      end
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if ({out_valid, result} !== {1'b1, 8'h07}) begin
         bad++;
         $display("FAIL b2b_second: got vld=%b res=%h want vld=1 res=07", out_valid, result);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      a = 8'hFD; b = 8'h05; op = 4'hB; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, result, carry_out, overflow, zero_flag, less_flag, equal_flag} !== {2'b01, 8'h00, 5'b00000}) begin
         bad++;
         $display("FAIL reset_mid: got vld=%b rdy=%b res=%h z=%b want vld=0 rdy=1 res=00 z=0",
                  out_valid, in_ready, result, zero_flag);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_one_op("add_after_rst", 8'h02, 8'h03, 4'h0, 0);
   endtask

   initial begin
      test_reset;
      test_directed;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

endmodule
